// File: rtl/mem_req_ctrl.sv
// Memory request controller: issues one client load/store at a time to the memory bus,
// retries on reject, and returns tagged load data to the client in acceptance order.
module mem_req_ctrl #(
    parameter int DEPTH     = 4,
    parameter int RETRY_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        st_done,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [31:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic        err_retry,
    output logic        err_tag
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RC_W  = $clog2(RETRY_MAX + 1);

    logic [0:0]       state;
    logic [1:0]       iss_cmd;
    logic [31:0]      iss_addr;
    logic [31:0]      iss_wdata;
    logic [RC_W-1:0]  retry_cnt;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_have;
    logic [3:0]       q_tag  [DEPTH];
    logic [31:0]      q_data [DEPTH];

    logic             accept;
    logic             issue_done;
    logic             push;
    logic             pop;
    logic             tag_hit;
    logic [PTR_W-1:0] hit_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stores bypass the full check; only loads occupy queue slots.
    assign req_ready  = rst && (state == S_IDLE) &&
                        (req_cmd == BUS_STORE || count < CNT_W'(DEPTH));
    assign accept     = req_valid && req_ready && (req_cmd == BUS_LOAD || req_cmd == BUS_STORE);
    assign issue_done = (state == S_ISSUE) && (mem2proc_response != 4'd0);
    assign push       = issue_done && (iss_cmd == BUS_LOAD);
    assign pop        = rsp_valid && rsp_ready;

    assign rsp_valid  = q_valid[head] && q_have[head];
    assign rsp_data   = rsp_valid ? q_data[head] : '0;

    assign proc2mem_command = (state == S_ISSUE) ? iss_cmd   : BUS_NONE;
    assign proc2mem_addr    = (state == S_ISSUE) ? iss_addr  : '0;
    assign proc2mem_data    = (state == S_ISSUE) ? iss_wdata : '0;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        tag_hit = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mem2proc_tag != 4'd0 && q_valid[i] && !q_have[i] && q_tag[i] == mem2proc_tag) begin
                tag_hit = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            iss_cmd   <= BUS_NONE;
            iss_addr  <= '0;
            iss_wdata <= '0;
            retry_cnt <= '0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            q_valid   <= '0;
            q_have    <= '0;
            st_done   <= 1'b0;
            err_retry <= 1'b0;
            err_tag   <= 1'b0;
        end else begin
            st_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        iss_cmd   <= req_cmd;
                        iss_addr  <= req_addr;
                        iss_wdata <= req_wdata;
                        state     <= S_ISSUE;
                    end
                end
                default: begin
                    if (mem2proc_response == 4'd0) begin
                        if (retry_cnt != RC_W'(RETRY_MAX))
                            retry_cnt <= retry_cnt + 1'b1;
                        if (retry_cnt >= RC_W'(RETRY_MAX - 1))
                            err_retry <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        retry_cnt <= '0;
                        if (iss_cmd == BUS_STORE)
                            st_done <= 1'b1;
                    end
                end
            endcase

            // Matching only sees pre-edge entries, so a tag never hits the slot pushed this edge.
            if (tag_hit)
                q_have[hit_idx] <= 1'b1;
            else if (mem2proc_tag != 4'd0)
                err_tag <= 1'b1;

            if (pop) begin
                q_valid[head] <= 1'b0;
                q_have[head]  <= 1'b0;
                head          <= next_ptr(head);
            end
            if (push) begin
                q_valid[tail] <= 1'b1;
                q_have[tail]  <= 1'b0;
                tail          <= next_ptr(tail);
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: tag/data storage is not reset; it is only ever read through q_valid/q_have, which are.
    always_ff @(posedge clk) begin
        if (push)
            q_tag[tail] <= mem2proc_response;
        if (tag_hit)
            q_data[hit_idx] <= mem2proc_data;
    end

endmodule
